// File: rtl/weighted_ring_arbiter.sv
// Weighted round-robin arbiter merging PORTS valid/ready streams into one buffered output.
// Optional packet lock: define LIBSV_WEIGHTED_RING_ARBITER_PACKET_LOCK_EN.
module weighted_ring_arbiter #(
    parameter int unsigned PORTS        = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 4
) (
    input  logic                          i_clock,
    input  logic                          i_areset,
    input  logic                          i_clear,
    input  logic [PORTS*DATA_WIDTH-1:0]   i_data,
    input  logic [PORTS-1:0]              i_last,
    input  logic [PORTS-1:0]              i_input_valid,
    input  logic [PORTS*WEIGHT_WIDTH-1:0] i_weights,
    input  logic                          i_output_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_last,
    output logic                          o_output_valid,
    output logic [PORTS-1:0]              o_input_ready,
    output logic [$clog2(PORTS)-1:0]      o_grant,
    output logic                          o_accept,
    output logic                          o_transmit
);

    localparam int unsigned GRANT_WIDTH = $clog2(PORTS);
    localparam logic [GRANT_WIDTH-1:0] LAST_PORT = GRANT_WIDTH'(PORTS - 1);

    logic [GRANT_WIDTH-1:0]  owner;
    logic [WEIGHT_WIDTH-1:0] credit;
    logic                    locked;

    logic [GRANT_WIDTH-1:0]  grant;
    logic [GRANT_WIDTH-1:0]  scan_idx;
    logic                    grant_found;
    logic [WEIGHT_WIDTH-1:0] grant_weight;
    logic [WEIGHT_WIDTH-1:0] eff_weight;
    logic [DATA_WIDTH-1:0]   grant_data;
    logic                    grant_last;
    logic                    new_tenure;

    logic [DATA_WIDTH-1:0]   buf_data [2];
    logic [1:0]              buf_last;
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [1:0]              count;
    logic                    buf_full;

    // Owner keeps the grant while it has credit (or holds the packet lock); else scan the ring.
    always_comb begin
        grant       = owner;
        grant_found = 1'b0;
        scan_idx    = owner;
        if (locked) begin
            grant_found = i_input_valid[owner];
        end else if ((credit != '0) && i_input_valid[owner]) begin
            grant_found = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= PORTS; k++) begin
                scan_idx = GRANT_WIDTH'((32'(owner) + k) % PORTS);
                if (!grant_found && i_input_valid[scan_idx]) begin
                    grant       = scan_idx;
                    grant_found = 1'b1;
                end
            end
        end
    end

    assign grant_weight = i_weights[32'(grant)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign eff_weight   = (grant_weight == '0) ? WEIGHT_WIDTH'(1) : grant_weight;
    assign grant_data   = i_data[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_last   = i_last[grant];
    assign new_tenure   = (grant != owner) || (credit == '0);

    assign buf_full = (count == 2'd2);
    assign o_accept = grant_found & ~buf_full & ~i_areset;

    always_comb begin
        o_input_ready = '0;
        if (o_accept) begin
            o_input_ready[grant] = 1'b1;
        end
    end

    // Grant ownership and credit; a clear on the same edge as an accept wins.
    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            owner  <= LAST_PORT;
            credit <= '0;
        end else if (i_clear) begin
            owner  <= LAST_PORT;
            credit <= '0;
        end else if (o_accept) begin
`ifdef LIBSV_WEIGHTED_RING_ARBITER_PACKET_LOCK_EN
            // Credit counts packets: a fresh tenure loads the full weight until its last beat.
            if (new_tenure) begin
                owner  <= grant;
                credit <= grant_last ? (eff_weight - WEIGHT_WIDTH'(1)) : eff_weight;
            end else if (grant_last) begin
                credit <= credit - WEIGHT_WIDTH'(1);
            end
`else
            if (new_tenure) begin
                owner  <= grant;
                credit <= eff_weight - WEIGHT_WIDTH'(1);
            end else begin
                credit <= credit - WEIGHT_WIDTH'(1);
            end
`endif
        end
    end

`ifdef LIBSV_WEIGHTED_RING_ARBITER_PACKET_LOCK_EN
    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            locked <= 1'b0;
        end else if (i_clear) begin
            locked <= 1'b0;
        end else if (o_accept) begin
            locked <= ~grant_last;
        end
    end
`else
    assign locked = 1'b0;
`endif

    // Two-entry output FIFO; every accepted beat is written, never bypassed.
    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else if (i_clear) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (o_accept) begin
                buf_data[wr_ptr] <= grant_data;
                buf_last[wr_ptr] <= grant_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (o_transmit) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(o_accept) - 2'(o_transmit);
        end
    end

    assign o_output_valid = (count != 2'd0);
    assign o_data         = buf_data[rd_ptr];
    assign o_last         = buf_last[rd_ptr];
    assign o_transmit     = o_output_valid & i_output_ready;
    assign o_grant        = owner;

endmodule

// File: doc/weighted_ring_arbiter.md
# weighted_ring_arbiter

Parametrised successor to the ring arbiter: a weighted round-robin arbiter that merges `PORTS` valid/ready input streams into one registered output stream. Each port holds the grant for a programmable number of consecutive transfers (its weight) before priority rotates to the next requesting port. An optional packet lock keeps the grant until the end of a multi-beat packet. It sits in front of shared single-consumer resources (buses, FIFOs, DMA channels) and replaces the plain ring arbiter where per-port bandwidth shares are needed.

## Interface
- `PORTS`, 4, number of input ports (≥2)
- `DATA_WIDTH`, 8, payload width per port
- `WEIGHT_WIDTH`, 4, width of each port's weight field
- `i_clock`  in  1  clock, all logic on rising edge
- `i_areset`  in  1  asynchronous, active-high reset
- `i_clear`  in  1  synchronous clear; same effect as reset
- `i_data`  in  PORTS*DATA_WIDTH  flattened payloads, port p at bits [p*DATA_WIDTH +: DATA_WIDTH]
- `i_last`  in  PORTS  end-of-packet flag per port
- `i_input_valid`  in  PORTS  per-port valid
- `i_weights`  in  PORTS*WEIGHT_WIDTH  flattened per-port weights; quasi-static
- `i_output_ready`  in  1  downstream ready
- `o_data`  out  DATA_WIDTH  output payload
- `o_last`  out  1  output end-of-packet flag
- `o_output_valid`  out  1  output valid
- `o_input_ready`  out  PORTS  per-port ready; at most one bit set
- `o_grant`  out  $clog2(PORTS)  index of the port currently owning the grant
- `o_accept`  out  1  a beat was accepted from an input this cycle
- `o_transmit`  out  1  a beat left on the output this cycle

## Operation
- State:
  - `owner`: port index
  - `credit`: WEIGHT_WIDTH-bit counter
  - `locked`: 1 bit, only with the lock macro
  - output skid buffer: 2 entries of {data, last}
- Effective weight: `w[p] = (i_weights[p] == 0) ? 1 : i_weights[p]`.
- Grant selection (combinational):
  - If `credit != 0` and `i_input_valid[owner]`, the grant is `owner`.
  - If `locked`, the grant is `owner` regardless of its valid.
  - Otherwise the grant is the first valid port scanning `owner+1, owner+2, …`, wrapping modulo PORTS; the scan ends at `owner` itself.
- `o_input_ready[g] = grant_valid & buffer_not_full`, where g is the granted port; all other bits are 0.
- Accept condition: `accept = i_input_valid[g] & o_input_ready[g]`.
- On accept of a beat from g:
  - If `g != owner` or `credit == 0`: set `owner <= g` and `credit <= w[g] - 1`.
  - Otherwise: `credit <= credit - 1`.
- Credit unit: one beat without the lock macro; one packet with it.
- When the owner drops valid with no lock held, its remaining credit is forfeited and the next accept reloads credit.
- `o_grant` reflects `owner`.
- The output skid buffer gives full throughput: one beat per cycle while `i_output_ready` is high.
- Ordering: beats leave in acceptance order.
- `o_transmit = o_output_valid & i_output_ready`.

## Timing
- Reset (async assert) and `i_clear` (next edge):
  - `owner = PORTS-1`, so port 0 has first priority.
  - `credit = 0`, `locked = 0`, skid buffer emptied.
  - `o_output_valid = 0`, `o_data = 0`, `o_last = 0`, `o_input_ready = 0`, `o_grant = PORTS-1`, `o_accept = 0`, `o_transmit = 0`.
- Reset deassertion: the first edge after release is ordinary operation.
- Latency: a beat accepted at edge N is on `o_data`/`o_output_valid` after edge N, i.e. in cycle N+1.
- `o_input_ready` depends combinationally on `i_input_valid` and the registered buffer state.
- No output depends combinationally on `i_output_ready` except `o_transmit`.
- Handshake rules:
  - An input must hold valid and data stable until accepted.
  - The output holds `o_data`/`o_last` stable while `o_output_valid & !i_output_ready`.
- Buffer full (2 entries): all `o_input_ready` are 0, and grant state does not change.
- Buffer states:
  - Empty with accept: entry written, no bypass.
  - Simultaneous accept and transmit with a non-empty buffer: occupancy unchanged.
- `i_clear` together with an accept: the clear wins and the beat is dropped.
- Changing `i_weights` takes effect at the next credit reload.

## Configuration
- Macro: `LIBSV_WEIGHTED_RING_ARBITER_PACKET_LOCK_EN`.
- Defined:
  - Accepting a beat with `i_last = 0` sets `locked`; accepting a beat with `i_last = 1` clears it.
  - Credit decrements and reloads only on accepts with `i_last = 1`.
  - Packets from different ports never interleave, even when the owner's valid drops mid-packet.
- Undefined:
  - `locked` is constant 0 and credit counts beats.
  - `i_last` is carried to `o_last` as sideband only.

## Test plan
- Reset with all four ports valid and weights 1, `i_output_ready = 1` -> accepts in order 0,1,2,3,0,1. First `o_output_valid` appears one cycle after the first accept.
- Weights {3,1,1,1}, all ports valid continuously -> accept order 0,0,0,1,2,3,0,0,0.
- Weight for port 2 = 0, all valid, other weights 1 -> port 2 receives exactly one beat per rotation.
- Hold `i_output_ready = 0` for 6 cycles with all ports valid -> exactly 2 beats accepted, then `o_input_ready = 0`. On release, all beats exit in acceptance order with no loss or duplication.
- With the macro, port 1 sends a 3-beat packet with valid low for 1 cycle after beat 1 while port 2 stays valid -> port 2 is not granted until port 1's `i_last` beat is accepted. Without the macro, port 2 is granted in the gap cycle.
- `i_clear` pulse while the buffer holds 2 beats and port 3 owns the grant with credit 2 -> next cycle `o_output_valid = 0` and `o_grant = 3` (PORTS-1). The next accept comes from port 0 when all ports are valid.
